eth_10g_tx_pkt_arbiter: RTL and testbench
=========================================

# eth_10g_tx_pkt_arbiter

Packet-granular two-input round-robin arbiter that shares the single 64-bit Avalon-ST transmit stream of the 10G Ethernet MAC between two frame sources (e.g. user traffic and a JTAG-driven debug/pause generator). It sits directly upstream of the TX timing adapter / frame decoder and locks the grant for a whole frame (SOP through EOP), so the MAC never sees interleaved frames. Ready latency is 0 on all ports. Per-source frame counters are kept for debug readout.

## Interface
- CNT_W, 32, width of per-input accepted-frame counters
- clk  in  1  clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high reset
- in0_valid / in1_valid  in  1  source valid
- in0_ready / in1_ready  out  1  source ready (ready latency 0)
- in0_data / in1_data  in  64  payload
- in0_error / in1_error  in  3  error
- in0_startofpacket / in1_startofpacket  in  1  SOP
- in0_endofpacket / in1_endofpacket  in  1  EOP
- in0_empty / in1_empty  in  3  empty bytes on EOP beat
- out_ready  in  1  sink ready
- out_valid, out_data[64], out_error[3], out_startofpacket, out_endofpacket, out_empty[3]  out  toward the MAC TX datapath
- grant  out  2  one-hot current owner ({in1,in0}); 2'b00 when idle
- pkt_cnt0 / pkt_cnt1  out  CNT_W  frames accepted from in0/in1, wrapping

## Operation
- States: IDLE, OWN0, OWN1. Encoded state is registered; grant = one-hot of OWN0/OWN1.
- Request of input k: ink_valid & ink_startofpacket. Non-SOP beats on a non-owning input never generate a request and are held (ready=0).
- Priority pointer last (1 bit, reset 1): when both request, the input != last wins; a single request wins outright. last updates to the winner whenever a grant is taken.
- IDLE: all in*_ready = 0, out_valid = 0. If any request, next state = OWN<winner>.
- OWNk: out_* = ink_* (combinational mux); ink_ready = out_ready; other input ready = 0.
- Beat accepted = out_valid & out_ready. On accepted beat with out_endofpacket = 1: pkt_cntk += 1 (wraps at 2^CNT_W), and re-arbitrate in the same cycle using the current requests (the finishing input included, at lower priority since last = k): next state = OWN<winner> or IDLE if no request.
- Single-beat frame (SOP & EOP same beat): counts once, re-arbitration as above.
- out_ready = 0 while OWNk: state holds, nothing accepted, counters hold.
- OWNk with ink_valid = 0 mid-frame: out_valid = 0, grant held (no timeout, no frame termination).
- Payload fields are passed unmodified; no checking of SOP within a locked frame.

## Timing
- Reset (synchronous): state = IDLE, last = 1, pkt_cnt0 = pkt_cnt1 = 0; hence out_valid = 0, grant = 0, in0_ready = in1_ready = 0 in the cycle after reset is sampled high and while it stays high.
- Reset mid-frame: grant dropped immediately; the truncated frame is not completed or flagged; counters cleared.
- IDLE to first output beat: 1 cycle (request seen in cycle n, OWN in n+1, SOP beat presented combinationally in n+1).
- Back-to-back frames: zero bubbles; the next owner's SOP beat can be accepted the cycle after the previous EOP was accepted.
- Datapath latency: 0 cycles (combinational mux from inputs to outputs while owned).
- Counter update is visible the cycle after the EOP acceptance.

## Test plan
- Reset then in0 sends 3-beat frame, out_ready = 1 -> grant 2'b01 one cycle after request, 3 beats on out unchanged, pkt_cnt0 = 1, state IDLE after, in1_ready = 0 throughout.
- Both inputs continuously offer 2-beat frames -> owners alternate in0, in1, in0, in1 with no idle cycles between EOP and next SOP; after 4 frames pkt_cnt0 = pkt_cnt1 = 2.
- in1 frame in progress, out_ready toggled 1,0,0,1 and in1_valid gapped one cycle -> grant stays 2'b10, no beat duplicated/lost, in0 SOP waiting is not accepted until in1 EOP accepted.
- Single-beat frames (SOP=EOP=1, empty=5) from in0 only, 4 back-to-back -> 4 output beats in 4 consecutive cycles after first grant, empty=5 passed, pkt_cnt0 = 4.
- CNT_W = 2, 5 frames from in0 -> pkt_cnt0 reads 1 (wrap).
- Reset asserted on 2nd beat of an in0 4-beat frame -> next cycle out_valid = 0, grant = 0, counters 0; after release in0 (priority) wins if both request.

Source files
------------

// File: rtl/eth_10g_tx_pkt_arbiter.sv
// eth_10g_tx_pkt_arbiter
// Packet-granular two-input round-robin arbiter in front of the 10G MAC TX
// Avalon-ST datapath. It locks the grant from SOP through EOP so that frames
// never interleave. Ready latency is 0 on all ports.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   in0_* / in1_*          source streams (valid/ready/data/error/sop/eop/empty)
//   out_*                  merged stream toward the MAC TX datapath
//   grant                  one-hot current owner {in1,in0}; 2'b00 when idle
//   pkt_cnt0 / pkt_cnt1    wrapping count of frames accepted from in0 / in1
module eth_10g_tx_pkt_arbiter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in0_valid,
   output logic             in0_ready,
   input  logic [63:0]      in0_data,
   input  logic [2:0]       in0_error,
   input  logic             in0_startofpacket,
   input  logic             in0_endofpacket,
   input  logic [2:0]       in0_empty,
   input  logic             in1_valid,
   output logic             in1_ready,
   input  logic [63:0]      in1_data,
   input  logic [2:0]       in1_error,
   input  logic             in1_startofpacket,
   input  logic             in1_endofpacket,
   input  logic [2:0]       in1_empty,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [63:0]      out_data,
   output logic [2:0]       out_error,
   output logic             out_startofpacket,
   output logic             out_endofpacket,
   output logic [2:0]       out_empty,
   output logic [1:0]       grant,
   output logic [CNT_W-1:0] pkt_cnt0,
   output logic [CNT_W-1:0] pkt_cnt1
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } state_t;

   state_t state, state_nxt;
   logic   last, last_nxt;
   logic   req0, req1, any_req, win1;
   logic   eop_acc;

   // Only an SOP beat may request; stray mid-frame beats are simply held.
   assign req0    = in0_valid & in0_startofpacket;
   assign req1    = in1_valid & in1_startofpacket;
   assign any_req = req0 | req1;
   // in1 wins when it is the only requester, or both request and in0 went last.
   assign win1    = req1 & (~req0 | ~last);
   assign eop_acc = out_valid & out_ready & out_endofpacket;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         last  <= 1'b1;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
      end
   end

   // Next-state: arbitrate from IDLE, or in the same cycle the EOP is accepted
   // so the next owner's SOP can go out with no bubble.
   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      if ((state == IDLE) || eop_acc) begin
         if (any_req) begin
            state_nxt = win1 ? OWN1 : OWN0;
            last_nxt  = win1;
         end else begin
            state_nxt = IDLE;
         end
      end
   end

   // Output mux: owner's stream passes straight through
   always_comb begin
      in0_ready         = 1'b0;
      in1_ready         = 1'b0;
      out_valid         = 1'b0;
      out_data          = '0;
      out_error         = '0;
      out_startofpacket = 1'b0;
      out_endofpacket   = 1'b0;
      out_empty         = '0;
      grant             = 2'b00;
      case (state)
         OWN0: begin
            grant             = 2'b01;
            in0_ready         = out_ready;
            out_valid         = in0_valid;
            out_data          = in0_data;
            out_error         = in0_error;
            out_startofpacket = in0_startofpacket;
            out_endofpacket   = in0_endofpacket;
            out_empty         = in0_empty;
         end
         OWN1: begin
            grant             = 2'b10;
            in1_ready         = out_ready;
            out_valid         = in1_valid;
            out_data          = in1_data;
            out_error         = in1_error;
            out_startofpacket = in1_startofpacket;
            out_endofpacket   = in1_endofpacket;
            out_empty         = in1_empty;
         end
         default: ;
      endcase
   end

   // Per-source frame counters, bumped on the accepted EOP beat
   always_ff @(posedge clk) begin
      if (reset) begin
         pkt_cnt0 <= '0;
         pkt_cnt1 <= '0;
      end else if (eop_acc) begin
         if (state == OWN0) pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
         if (state == OWN1) pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_eth_10g_tx_pkt_arbiter.sv
// Directed self-checking bench for eth_10g_tx_pkt_arbiter. A second instance
// with CNT_W = 2 shares the stimulus and is used for the counter-wrap check.
module tb_eth_10g_tx_pkt_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        in0_valid, in0_startofpacket, in0_endofpacket;
   logic        in1_valid, in1_startofpacket, in1_endofpacket;
   logic [63:0] in0_data, in1_data;
   logic [2:0]  in0_error, in0_empty, in1_error, in1_empty;
   logic        out_ready;

   logic        in0_ready, in1_ready, out_valid, out_startofpacket, out_endofpacket;
   logic [63:0] out_data;
   logic [2:0]  out_error, out_empty;
   logic [1:0]  grant;
   logic [31:0] pkt_cnt0, pkt_cnt1;

   logic        w2_in0_ready, w2_in1_ready, w2_out_valid, w2_out_sop, w2_out_eop;
   logic [63:0] w2_out_data;
   logic [2:0]  w2_out_error, w2_out_empty;
   logic [1:0]  w2_grant;
   logic [1:0]  w2_pkt_cnt0, w2_pkt_cnt1;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   eth_10g_tx_pkt_arbiter #(.CNT_W(32)) dut (
      .clk(clk), .reset(reset),
      .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data),
      .in0_error(in0_error), .in0_startofpacket(in0_startofpacket),
      .in0_endofpacket(in0_endofpacket), .in0_empty(in0_empty),
      .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data),
      .in1_error(in1_error), .in1_startofpacket(in1_startofpacket),
      .in1_endofpacket(in1_endofpacket), .in1_empty(in1_empty),
      .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
      .out_error(out_error), .out_startofpacket(out_startofpacket),
      .out_endofpacket(out_endofpacket), .out_empty(out_empty),
      .grant(grant), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
   );

   eth_10g_tx_pkt_arbiter #(.CNT_W(2)) dut_w2 (
      .clk(clk), .reset(reset),
      .in0_valid(in0_valid), .in0_ready(w2_in0_ready), .in0_data(in0_data),
      .in0_error(in0_error), .in0_startofpacket(in0_startofpacket),
      .in0_endofpacket(in0_endofpacket), .in0_empty(in0_empty),
      .in1_valid(in1_valid), .in1_ready(w2_in1_ready), .in1_data(in1_data),
      .in1_error(in1_error), .in1_startofpacket(in1_startofpacket),
      .in1_endofpacket(in1_endofpacket), .in1_empty(in1_empty),
      .out_ready(out_ready), .out_valid(w2_out_valid), .out_data(w2_out_data),
      .out_error(w2_out_error), .out_startofpacket(w2_out_sop),
      .out_endofpacket(w2_out_eop), .out_empty(w2_out_empty),
      .grant(w2_grant), .pkt_cnt0(w2_pkt_cnt0), .pkt_cnt1(w2_pkt_cnt1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv0(input logic v, input logic sop, input logic eop,
                       input logic [63:0] d, input logic [2:0] emp, input logic [2:0] err);
      in0_valid = v; in0_startofpacket = sop; in0_endofpacket = eop;
      in0_data = d; in0_empty = emp; in0_error = err;
   endtask

   task automatic drv1(input logic v, input logic sop, input logic eop,
                       input logic [63:0] d, input logic [2:0] emp, input logic [2:0] err);
      in1_valid = v; in1_startofpacket = sop; in1_endofpacket = eop;
      in1_data = d; in1_empty = emp; in1_error = err;
   endtask

   task automatic idle_all();
      drv0(1'b0, 1'b0, 1'b0, '0, '0, '0);
      drv1(1'b0, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_all();
      step();
      reset = 1'b0;
   endtask

   // Reset held with both inputs requesting: everything must stay quiet.
   task automatic test_reset();
      reset = 1'b1;
      out_ready = 1'b1;
      drv0(1'b1, 1'b1, 1'b0, 64'h11, '0, '0);
      drv1(1'b1, 1'b1, 1'b0, 64'h22, '0, '0);
      step();
      step();
      @(negedge clk);
      n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b exp 0", out_valid); else n_pass++;
      n_total++; if (grant !== 2'b00) $display("FAIL rst_grant: got %b exp 00", grant); else n_pass++;
      n_total++; if ({in1_ready, in0_ready} !== 2'b00) $display("FAIL rst_ready: got %b exp 00", {in1_ready, in0_ready}); else n_pass++;
      n_total++; if (pkt_cnt0 !== 32'd0 || pkt_cnt1 !== 32'd0) $display("FAIL rst_cnt: got %0d/%0d exp 0/0", pkt_cnt0, pkt_cnt1); else n_pass++;
      step();
      reset = 1'b0;
      idle_all();
      step();
   endtask

   // 3-beat frame from in0; in1 holds a non-SOP beat which must never be taken.
   task automatic test_single_frame();
      out_ready = 1'b1;
      drv1(1'b1, 1'b0, 1'b0, 64'hBAD1, '0, '0);
      drv0(1'b1, 1'b1, 1'b0, 64'hA0, '0, '0);
      @(negedge clk);
      n_total++; if (grant !== 2'b00) $display("FAIL sf_grant_req: got %b exp 00", grant); else n_pass++;
      step();
      @(negedge clk);
      n_total++; if (grant !== 2'b01) $display("FAIL sf_grant: got %b exp 01", grant); else n_pass++;
      n_total++; if (out_data !== 64'hA0 || out_startofpacket !== 1'b1) $display("FAIL sf_beat0: got %h sop %b exp a0 sop 1", out_data, out_startofpacket); else n_pass++;
      n_total++; if (in0_ready !== 1'b1 || in1_ready !== 1'b0) $display("FAIL sf_ready0: got %b%b exp 01", in1_ready, in0_ready); else n_pass++;
      step();
      drv0(1'b1, 1'b0, 1'b0, 64'hA1, '0, 3'b101);
      @(negedge clk);
      n_total++; if (out_data !== 64'hA1 || out_error !== 3'b101) $display("FAIL sf_beat1: got %h err %b exp a1 err 101", out_data, out_error); else n_pass++;
      n_total++; if (in1_ready !== 1'b0) $display("FAIL sf_in1_ready1: got %b exp 0", in1_ready); else n_pass++;
      step();
      drv0(1'b1, 1'b0, 1'b1, 64'hA2, 3'd3, '0);
      @(negedge clk);
      n_total++; if (out_data !== 64'hA2 || out_endofpacket !== 1'b1 || out_empty !== 3'd3) $display("FAIL sf_beat2: got %h eop %b empty %0d exp a2 1 3", out_data, out_endofpacket, out_empty); else n_pass++;
      n_total++; if (in1_ready !== 1'b0) $display("FAIL sf_in1_ready2: got %b exp 0", in1_ready); else n_pass++;
      step();
      idle_all();
      @(negedge clk);
      n_total++; if (grant !== 2'b00) $display("FAIL sf_grant_after: got %b exp 00", grant); else n_pass++;
      n_total++; if (pkt_cnt0 !== 32'd1 || pkt_cnt1 !== 32'd0) $display("FAIL sf_cnt: got %0d/%0d exp 1/0", pkt_cnt0, pkt_cnt1); else n_pass++;
      step();
   endtask

   // Both sources stream 2-beat frames continuously; owners must alternate
   // with no idle cycle between an EOP and the next SOP.
   task automatic test_back_to_back();
      logic [1:0]  exp_g [9] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};
      int          b0 = 0, b1 = 0, f0 = 0, f1 = 0;
      logic        acc0, acc1;
      logic [63:0] d0, d1, exp_d;
      do_reset();
      out_ready = 1'b1;
      for (int c = 0; c < 9; c++) begin
         d0 = {32'h0, 16'hC000, 8'(f0), 8'(b0)};
         d1 = {32'h0, 16'hD000, 8'(f1), 8'(b1)};
         drv0(1'b1, b0 == 0, b0 == 1, d0, '0, '0);
         drv1(1'b1, b1 == 0, b1 == 1, d1, '0, '0);
         @(negedge clk);
         n_total++; if (grant !== exp_g[c]) $display("FAIL b2b_grant c%0d: got %b exp %b", c, grant, exp_g[c]); else n_pass++;
         if (c > 0) begin
            exp_d = (exp_g[c] == 2'b01) ? d0 : d1;
            n_total++; if (out_valid !== 1'b1 || out_data !== exp_d) $display("FAIL b2b_data c%0d: got v%b %h exp v1 %h", c, out_valid, out_data, exp_d); else n_pass++;
         end
         acc0 = in0_ready;
         acc1 = in1_ready;
         step();
         if (acc0) begin if (b0 == 1) f0++; b0 = 1 - b0; end
         if (acc1) begin if (b1 == 1) f1++; b1 = 1 - b1; end
      end
      @(negedge clk);
      n_total++; if (pkt_cnt0 !== 32'd2 || pkt_cnt1 !== 32'd2) $display("FAIL b2b_cnt: got %0d/%0d exp 2/2", pkt_cnt0, pkt_cnt1); else n_pass++;
      step();
   endtask

   // in1 frame with sink stalls and a source gap; in0 SOP waits the whole time.
   task automatic test_stall();
      do_reset();
      out_ready = 1'b1;
      drv1(1'b1, 1'b1, 1'b0, 64'h10, '0, '0);
      step();
      drv0(1'b1, 1'b1, 1'b0, 64'h20, '0, '0);
      @(negedge clk);
      n_total++; if (grant !== 2'b10 || out_data !== 64'h10 || in1_ready !== 1'b1) $display("FAIL st_c1: got g%b %h r%b exp g10 10 r1", grant, out_data, in1_ready); else n_pass++;
      step();
      drv1(1'b1, 1'b0, 1'b0, 64'h11, '0, '0);
      out_ready = 1'b0;
      @(negedge clk);
      n_total++; if (out_valid !== 1'b1 || out_data !== 64'h11 || in1_ready !== 1'b0) $display("FAIL st_c2: got v%b %h r%b exp v1 11 r0", out_valid, out_data, in1_ready); else n_pass++;
      step();
      @(negedge clk);
      n_total++; if (grant !== 2'b10 || in0_ready !== 1'b0 || out_data !== 64'h11) $display("FAIL st_c3: got g%b r0 %b %h exp g10 r0 0 11", grant, in0_ready, out_data); else n_pass++;
      step();
      out_ready = 1'b1;
      @(negedge clk);
      n_total++; if (in1_ready !== 1'b1 || out_data !== 64'h11) $display("FAIL st_c4: got r%b %h exp r1 11", in1_ready, out_data); else n_pass++;
      step();
      drv1(1'b0, 1'b0, 1'b0, 64'h0, '0, '0);
      @(negedge clk);
      n_total++; if (out_valid !== 1'b0 || grant !== 2'b10 || in0_ready !== 1'b0) $display("FAIL st_gap: got v%b g%b r0 %b exp v0 g10 r0 0", out_valid, grant, in0_ready); else n_pass++;
      step();
      drv1(1'b1, 1'b0, 1'b1, 64'h12, '0, '0);
      @(negedge clk);
      n_total++; if (out_data !== 64'h12 || out_endofpacket !== 1'b1 || grant !== 2'b10) $display("FAIL st_eop: got %h eop %b g%b exp 12 1 10", out_data, out_endofpacket, grant); else n_pass++;
      step();
      drv1(1'b0, 1'b0, 1'b0, 64'h0, '0, '0);
      @(negedge clk);
      n_total++; if (grant !== 2'b01 || out_data !== 64'h20 || in0_ready !== 1'b1) $display("FAIL st_handover: got g%b %h r%b exp g01 20 r1", grant, out_data, in0_ready); else n_pass++;
      n_total++; if (pkt_cnt1 !== 32'd1 || pkt_cnt0 !== 32'd0) $display("FAIL st_cnt: got %0d/%0d exp 0/1", pkt_cnt0, pkt_cnt1); else n_pass++;
      step();
   endtask

   // Four single-beat frames from in0, one per cycle after the grant.
   task automatic test_single_beat();
      do_reset();
      out_ready = 1'b1;
      drv0(1'b1, 1'b1, 1'b1, 64'h30, 3'd5, '0);
      step();
      for (int i = 0; i < 4; i++) begin
         drv0(1'b1, 1'b1, 1'b1, 64'h30 + 64'(i), 3'd5, '0);
         @(negedge clk);
         n_total++; if (grant !== 2'b01 || out_valid !== 1'b1 || out_data !== 64'h30 + 64'(i) || out_empty !== 3'd5)
            $display("FAIL sb_beat%0d: got g%b v%b %h e%0d exp g01 v1 %h e5", i, grant, out_valid, out_data, out_empty, 64'h30 + 64'(i));
         else n_pass++;
         step();
      end
      idle_all();
      @(negedge clk);
      n_total++; if (pkt_cnt0 !== 32'd4) $display("FAIL sb_cnt: got %0d exp 4", pkt_cnt0); else n_pass++;
      step();
   endtask

   // Five frames from in0: the 2-bit instance must wrap to 1.
   task automatic test_wrap();
      do_reset();
      out_ready = 1'b1;
      drv0(1'b1, 1'b1, 1'b1, 64'h40, '0, '0);
      step();
      for (int i = 0; i < 5; i++) begin
         drv0(1'b1, 1'b1, 1'b1, 64'h40 + 64'(i), '0, '0);
         step();
      end
      idle_all();
      @(negedge clk);
      n_total++; if (w2_pkt_cnt0 !== 2'd1) $display("FAIL wrap_cnt_w2: got %0d exp 1", w2_pkt_cnt0); else n_pass++;
      n_total++; if (pkt_cnt0 !== 32'd5) $display("FAIL wrap_cnt_w32: got %0d exp 5", pkt_cnt0); else n_pass++;
      step();
   endtask

   // Reset on beat 2 of an in0 frame; counters (5 from the wrap test) clear.
   task automatic test_reset_mid();
      logic got = 1'b0;
      out_ready = 1'b1;
      drv0(1'b1, 1'b1, 1'b0, 64'hE0, '0, '0);
      for (int k = 0; k < 4 && !got; k++) begin
         @(negedge clk);
         if (in0_ready === 1'b1) got = 1'b1;
         step();
      end
      n_total++; if (!got) $display("FAIL rm_sop_accept: got none exp accepted within 4 cycles"); else n_pass++;
      drv0(1'b1, 1'b0, 1'b0, 64'hE1, '0, '0);
      reset = 1'b1;
      @(negedge clk);
      n_total++; if (grant !== 2'b01) $display("FAIL rm_grant_pre: got %b exp 01", grant); else n_pass++;
      step();
      drv0(1'b1, 1'b1, 1'b0, 64'hF0, '0, '0);
      drv1(1'b1, 1'b1, 1'b0, 64'hF1, '0, '0);
      @(negedge clk);
      n_total++; if (out_valid !== 1'b0 || grant !== 2'b00 || in0_ready !== 1'b0) $display("FAIL rm_drop: got v%b g%b r%b exp v0 g00 r0", out_valid, grant, in0_ready); else n_pass++;
      n_total++; if (pkt_cnt0 !== 32'd0 || w2_pkt_cnt0 !== 2'd0) $display("FAIL rm_cnt: got %0d/%0d exp 0/0", pkt_cnt0, w2_pkt_cnt0); else n_pass++;
      step();
      reset = 1'b0;
      @(negedge clk);
      n_total++; if (grant !== 2'b00) $display("FAIL rm_idle: got %b exp 00", grant); else n_pass++;
      step();
      @(negedge clk);
      n_total++; if (grant !== 2'b01 || out_data !== 64'hF0 || in1_ready !== 1'b0) $display("FAIL rm_prio: got g%b %h r1 %b exp g01 f0 r1 0", grant, out_data, in1_ready); else n_pass++;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      out_ready = 1'b0;
      idle_all();
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_stall();
      test_single_beat();
      test_wrap();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
